// File: rtl/jtag_shift_pkg.sv
// Shared width helpers for the JTAG word transmitter/receiver pair.
package jtag_shift_pkg;

  localparam int WORD_WIDTH_DEFAULT = 32;

  // Counter must reach WIDTH, hence the +1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/word_receiver.sv
// MSB-first serial-to-parallel receiver; a word is valid the cycle after its last enabled bit.
// Completed words wait on a valid/ready port; a word finishing while out is unconsumed is dropped and flagged.
module word_receiver
  import jtag_shift_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           in,
  output logic [WIDTH-1:0]               out,
  output logic                           valid,
  input  logic                           ready,
  output logic [cnt_width(WIDTH)-1:0]    count,
  output logic                           overrun,
  output logic                           aborted
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic             take;

  assign word     = {sr, in};
  assign last_bit = enable && (count == LAST);
  assign take     = valid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      count   <= '0;
      out     <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      aborted <= 1'b0;
    end else begin
      aborted <= 1'b0;
      if (enable) begin
        if (last_bit) begin
          sr    <= '0;
          count <= '0;
          // A word completing on the same edge as a handshake replaces the consumed one.
          if (!valid || take) begin
            out   <= word;
            valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          sr    <= word[WIDTH-2:0];
          count <= count + 1'b1;
        end
      end else begin
        sr      <= '0;
        count   <= '0;
        aborted <= (count != '0);
      end
      if (take && !last_bit) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
